unified_mem_arbiter: RTL

- Shares the single-port unified instruction/data memory between two requesters: the IF fetch path and the MEM-stage load/store path.
- Grants one transaction at a time and sequences the memory port over a fixed LATENCY.
- Returns data with a one-cycle ack and exposes per-requester stall signals that freeze the pipeline.
- Data accesses have priority. A streak counter guarantees fetch progress when data accesses are continuous.

---
 rtl/unified_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port instruction/data memory
// between the fetch path (I) and the load/store path (D). Data accesses
// win arbitration. A streak counter forces a fetch grant once STARVE_MAX
// data grants have been made back-to-back while a fetch was waiting.
// One transaction at a time: grant (IDLE) -> ISSUE (mem_en) -> WAIT (ack).
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STREAK_SAT = 4'd15;

    // owner encoding: 0 = fetch (I), 1 = data (D)
    logic [1:0]        state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [3:0]        streak_q, streak_d;
    logic              owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic              ack_cycle_s;
    logic              fetch_forced_s;

    // Fetch wins a simultaneous request only once the data streak has reached the limit.
    assign fetch_forced_s = if_req && (streak_q >= STARVE_LIM);

    // Next-state logic: arbitration in IDLE, issue strobe, latency countdown.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        case (state_q)
            IDLE: begin
                if (d_req && !fetch_forced_s) begin
                    owner_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    state_d = ISSUE;
                    // Streak only measures data grants that kept a waiting fetch out.
                    if (if_req && (streak_q != STREAK_SAT)) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = streak_q;
                    end
                end else if (if_req) begin
                    owner_d  = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = {DATA_W{1'b0}};
                    we_d     = 1'b0;
                    streak_d = 4'd0;
                    state_d  = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and capture registers; reset discards any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            streak_q <= 4'd0;
            owner_q  <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    // Memory port and acks decode purely from registers, so they are clean for the whole cycle.
    assign ack_cycle_s = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_en      = (state_q == ISSUE);
    assign mem_we      = mem_en && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_ack      = ack_cycle_s && !owner_q;
    assign d_ack       = ack_cycle_s && owner_q;
    assign if_rdata    = if_ack ? mem_rdata : {DATA_W{1'b0}};
    assign d_rdata     = (d_ack && !we_q) ? mem_rdata : {DATA_W{1'b0}};
    assign if_stall    = if_req && !if_ack;
    assign d_stall     = d_req && !d_ack;
    assign busy        = (state_q != IDLE);

endmodule
